seq_mul_arbiter: RTL and testbench
==================================

# seq_mul_arbiter

Round-robin arbiter and sequencer that shares one 32-bit sequential multiplier between `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and pulses the multiplier start. It then counts the multiplier's fixed latency, because the multiplier has no done flag. Finally it returns the 64-bit product to the winning requester over a valid/ready response channel tagged with the requester index. It sits between the requester clients and the multiplier's `start_i`/`a_i`/`b_i`/`product_o` pins.

## Interface
- `NUM_REQ`, 4, number of requesters, 2..16
- `WIDTH`, 32, operand width; product is 2*WIDTH
- `MUL_LATENCY`, 33, cycles from the start-pulse cycle to a valid `mul_product_i`, >=1
- `clk_i`  in  1  single clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `req_valid_i`  in  NUM_REQ  per-requester request valid
- `req_ready_o`  out  NUM_REQ  per-requester accept; at most one bit set
- `req_a_i`  in  NUM_REQ*WIDTH  operand A; requester k at bits [k*WIDTH +: WIDTH]
- `req_b_i`  in  NUM_REQ*WIDTH  operand B, same packing
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response accepted by the consumer
- `rsp_id_o`  out  $clog2(NUM_REQ)  index of the requester that owns the response
- `rsp_product_o`  out  2*WIDTH  product a*b, unsigned
- `mul_start_o`  out  1  one-cycle start pulse to the multiplier
- `mul_a_o`  out  WIDTH  multiplier operand A, held stable for the whole operation
- `mul_b_o`  out  WIDTH  multiplier operand B, held stable for the whole operation
- `mul_product_i`  in  2*WIDTH  multiplier product
- `busy_o`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, START, BUSY, RESP.
- **IDLE**
  - If any `req_valid_i` bit is set, grant the first set bit found searching upward from `ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready_o[grant]` combinationally in the same cycle.
  - Capture the granted operands into `op_a`/`op_b` and the index into `id_q`, then go to START.
  - With no valid requests, stay in IDLE with `req_ready_o` = 0.
- **Pointer update**: on accept, `ptr <= (grant+1) mod NUM_REQ`.
- **START**: `mul_start_o` = 1 for exactly this cycle. Load the counter with MUL_LATENCY, then go to BUSY.
- **BUSY**
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 1, register `mul_product_i` into `rsp_product_o` and go to RESP.
  - BUSY therefore lasts exactly MUL_LATENCY cycles.
- **RESP**
  - `rsp_valid_o` = 1.
  - `rsp_id_o` and `rsp_product_o` stay stable until `rsp_valid_o && rsp_ready_i`, then return to IDLE.
- **Signal levels**
  - `req_ready_o` is 0 in START, BUSY and RESP, so no new request is accepted until the response handshake completes.
  - `mul_a_o`/`mul_b_o` = `op_a`/`op_b` in all states. They change only on accept.
- **Counter width**: $clog2(MUL_LATENCY+1).
- **Arithmetic**: the block does no arithmetic on the product; it is passed through unsigned and unmodified.
- **Requester-side contract**: a requester holds `req_valid_i` and its operands until it sees `req_ready_o`. A request that deasserts before being granted is simply not served.
- **Reset**
  - `rst_i` high in any state forces IDLE on the next edge.
  - The in-flight operation is dropped and no response is issued.
  - `ptr` returns to 0.

## Timing
- Reset values: `req_ready_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_product_o`=0, `mul_start_o`=0, `mul_a_o`=0, `mul_b_o`=0, `busy_o`=0, `ptr`=0, state IDLE.
- Accept handshake in cycle T.
  - `mul_start_o` high in T+1.
  - BUSY covers T+2..T+1+MUL_LATENCY.
  - `mul_product_i` is sampled at the end of T+1+MUL_LATENCY.
  - `rsp_valid_o` is first high in T+2+MUL_LATENCY.
- Minimum issue interval: with `rsp_ready_i` held high, accept-to-accept is MUL_LATENCY+3 cycles (accept, START, BUSY, RESP, then IDLE).
- `req_ready_o` depends combinationally on `req_valid_i` and `ptr`. All other outputs are registered.
- If `req_valid_i` is raised in the same cycle as the response handshake, it is not seen until the next cycle, which is IDLE.

## Test plan
- **Single request:** requester 2 sends a=3, b=5 with `rsp_ready_i`=1 → `req_ready_o`=4'b0100 in T; `mul_start_o` pulses in T+1; `rsp_valid_o` in T+35 with `rsp_id_o`=2 and `rsp_product_o`=15.
- **All four requesters valid from reset**, operands k+1 and 10 → responses in id order 0,1,2,3 with products 10,20,30,40; accepts are 36 cycles apart.
- **Round-robin wrap:** after serving id 2, requesters 0 and 3 are valid together → id 3 is granted first, then id 0.
- **Response backpressure:** `rsp_ready_i` held low for 10 cycles in RESP → `rsp_valid_o`, `rsp_id_o` and `rsp_product_o` stay stable, `req_ready_o` stays 0, and `mul_start_o` stays 0.
- **Maximum operands:** a=b=0xFFFFFFFF → `rsp_product_o`=0xFFFFFFFE00000001; `mul_a_o`/`mul_b_o` are constant through BUSY.
- **Reset mid-BUSY:** `rst_i` pulsed in cycle 10 of BUSY → all outputs reach reset values next edge and no `rsp_valid_o` follows. A fresh request from requester 1 is then served normally, with the grant searching from `ptr`=0.

Source files
------------

// File: rtl/seq_mul_arbiter.sv
// seq_mul_arbiter: round-robin sharing of one fixed-latency sequential multiplier
module seq_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 33
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0]     req_a_i,
   input  logic [NUM_REQ*WIDTH-1:0]     req_b_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o,
   output logic [2*WIDTH-1:0]           rsp_product_o,
   output logic                         mul_start_o,
   output logic [WIDTH-1:0]             mul_a_o,
   output logic [WIDTH-1:0]             mul_b_o,
   input  logic [2*WIDTH-1:0]           mul_product_i,
   output logic                         busy_o
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MUL_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, grant, id_q, idx;
   logic [CW-1:0]   cnt_q;
   logic [WIDTH-1:0] op_a, op_b;
   logic            found, accept;
   int              s;

   // first valid requester at or above ptr, wrapping
   always_comb begin
      grant = ptr_q;
      found = 1'b0;
      s     = 0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         s   = int'(ptr_q) + i;
         s   = (s >= NUM_REQ) ? s - NUM_REQ : s;
         idx = IW'(s);
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      accept      = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            req_ready_o[grant] = 1'b1;
            accept             = 1'b1;
            state_d            = START;
         end
         START:   state_d = BUSY;
         BUSY:    state_d = (cnt_q == CW'(1)) ? RESP : BUSY;
         RESP:    state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q         <= '0;
         id_q          <= '0;
         op_a          <= '0;
         op_b          <= '0;
         cnt_q         <= '0;
         rsp_product_o <= '0;
      end else begin
         if (accept) begin
            ptr_q <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            id_q  <= grant;
            op_a  <= req_a_i[int'(grant)*WIDTH +: WIDTH];
            op_b  <= req_b_i[int'(grant)*WIDTH +: WIDTH];
         end
         // the multiplier has no done flag, so its latency is counted here
         if (state_q == START)     cnt_q <= CW'(MUL_LATENCY);
         else if (state_q == BUSY) cnt_q <= cnt_q - 1'b1;
         if (state_q == BUSY && cnt_q == CW'(1)) rsp_product_o <= mul_product_i;
      end
   end

   assign rsp_valid_o = (state_q == RESP);
   assign mul_start_o = (state_q == START);
   assign busy_o      = (state_q != IDLE);
   assign rsp_id_o    = id_q;
   assign mul_a_o     = op_a;
   assign mul_b_o     = op_b;
endmodule

// File: tb/tb_seq_mul_arbiter.sv
// tb_seq_mul_arbiter: directed stimulus with a response scoreboard and a latency-exact multiplier model
module tb_seq_mul_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 33;

   typedef struct packed {
      logic [1:0]  id;
      logic [63:0] p;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [N-1:0] req_valid, req_ready;
   logic [W-1:0] a_arr [N];
   logic [W-1:0] b_arr [N];
   logic [N*W-1:0] req_a, req_b;
   logic         rsp_valid, rsp_ready, mul_start, busy;
   logic [1:0]   rsp_id;
   logic [63:0]  rsp_product, mul_product;
   logic [W-1:0] mul_a, mul_b;

   exp_t exp_q[$];
   int   acc_cyc[$];
   int   acc_id[$];
   int   cyc = 0, mcnt = 0, n_rsp = 0, last_rise = -1;
   int   n_pass = 0, n_tot = 0;
   logic prev_v = 1'b0;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_a[g*W +: W] = a_arr[g];
      assign req_b[g*W +: W] = b_arr[g];
   end

   seq_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_product_o(rsp_product),
      .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
      .mul_product_i(mul_product), .busy_o(busy)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // product is only correct in the single cycle L cycles after the start pulse
   always @(posedge clk_i) begin
      if (rst_i)                       mcnt <= 0;
      else if (mul_start)              mcnt <= 1;
      else if (mcnt != 0 && mcnt < L)  mcnt <= mcnt + 1;
      else                             mcnt <= 0;
   end
   assign mul_product = (mcnt == L) ? {32'b0, mul_a} * {32'b0, mul_b} : 64'hDEAD_BEEF_0BAD_F00D;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (rsp_valid && !prev_v) last_rise = cyc;
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_id", {62'b0, rsp_id}, {62'b0, e.id});
            chk("rsp_product", rsp_product, e.p);
         end
      end
   end

   task automatic tick();
      logic [N-1:0] hs;
      exp_t e;
      #1;
      hs = rst_i ? '0 : (req_valid & req_ready);
      for (int k = 0; k < N; k++) if (hs[k]) begin
         e.id = 2'(k);
         e.p  = {32'b0, a_arr[k]} * {32'b0, b_arr[k]};
         exp_q.push_back(e);
         acc_cyc.push_back(cyc);
         acc_id.push_back(k);
      end
      @(posedge clk_i);
      #1 req_valid = req_valid & ~hs;
      @(negedge clk_i);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || busy || req_valid != 0) && n < 400) begin
         tick();
         n++;
      end
      chk(nm, {63'b0, n < 400}, 1);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      exp_q.delete();
      acc_cyc.delete();
      acc_id.delete();
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_req_ready"}, {60'b0, req_ready}, 0);
      chk({p, "_rsp_valid"}, {63'b0, rsp_valid}, 0);
      chk({p, "_rsp_id"}, {62'b0, rsp_id}, 0);
      chk({p, "_rsp_product"}, rsp_product, 0);
      chk({p, "_mul_start"}, {63'b0, mul_start}, 0);
      chk({p, "_mul_a"}, {32'b0, mul_a}, 0);
      chk({p, "_mul_b"}, {32'b0, mul_b}, 0);
      chk({p, "_busy"}, {63'b0, busy}, 0);
   endtask

   initial begin
      int t0, nr, lr, n;
      rst_i = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         a_arr[k] = '0;
         b_arr[k] = '0;
      end
      do_reset();
      chk_reset_vals("rst");

      // single request from requester 2
      a_arr[2] = 3; b_arr[2] = 5; req_valid = 4'b0100;
      #1 chk("t1_ready", {60'b0, req_ready}, 4'b0100);
      t0 = cyc;
      tick();
      chk("t1_start", {63'b0, mul_start}, 1);
      chk("t1_busy", {63'b0, busy}, 1);
      tick();
      chk("t1_start_low", {63'b0, mul_start}, 0);
      wait_done("t1_done");
      chk("t1_rsp_cycle", 64'(last_rise), 64'(t0 + 35));

      // ptr now 3: requesters 0 and 3 together
      acc_id.delete();
      a_arr[0] = 11; b_arr[0] = 2; a_arr[3] = 13; b_arr[3] = 3; req_valid = 4'b1001;
      #1 chk("t3_ready", {60'b0, req_ready}, 4'b1000);
      wait_done("t3_done");
      chk("t3_n_acc", 64'(acc_id.size()), 2);
      if (acc_id.size() == 2) begin
         chk("t3_first", 64'(acc_id[0]), 3);
         chk("t3_second", 64'(acc_id[1]), 0);
      end

      // all four valid through reset
      for (int k = 0; k < N; k++) begin
         a_arr[k] = W'(k + 1);
         b_arr[k] = 10;
      end
      req_valid = 4'b1111;
      do_reset();
      wait_done("t2_done");
      chk("t2_n_acc", 64'(acc_id.size()), 4);
      if (acc_id.size() == 4) for (int k = 0; k < 4; k++) begin
         chk("t2_order", 64'(acc_id[k]), 64'(k));
         if (k > 0) chk("t2_interval", 64'(acc_cyc[k] - acc_cyc[k-1]), 36);
      end

      // response backpressure
      rsp_ready = 1'b0;
      a_arr[1] = 9; b_arr[1] = 9; req_valid = 4'b0010;
      n = 0;
      while (!rsp_valid && n < 60) begin
         tick();
         n++;
      end
      chk("t4_reach_resp", {63'b0, rsp_valid}, 1);
      a_arr[0] = 2; b_arr[0] = 2; req_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("t4_valid", {63'b0, rsp_valid}, 1);
         chk("t4_id", {62'b0, rsp_id}, 1);
         chk("t4_product", rsp_product, 81);
         chk("t4_req_ready", {60'b0, req_ready}, 0);
         chk("t4_start", {63'b0, mul_start}, 0);
         tick();
      end
      @(posedge clk_i);
      #1 rsp_ready = 1'b1;
      @(negedge clk_i);
      wait_done("t4_done");

      // maximum operands, inputs changed after accept
      a_arr[3] = '1; b_arr[3] = '1; req_valid = 4'b1000;
      tick();
      a_arr[3] = 0; b_arr[3] = 0;
      tick();
      n = 0;
      while (busy && !rsp_valid && n < 60) begin
         chk("t5_mul_a", {32'b0, mul_a}, 64'hFFFF_FFFF);
         chk("t5_mul_b", {32'b0, mul_b}, 64'hFFFF_FFFF);
         tick();
         n++;
      end
      chk("t5_busy_len", 64'(n), L);
      chk("t5_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
      wait_done("t5_done");

      // reset in BUSY cycle 10 after granting requester 2 (ptr would become 3)
      a_arr[2] = 4; b_arr[2] = 4; req_valid = 4'b0100;
      tick();
      tick();
      repeat (9) tick();
      chk("t6_in_busy", {63'b0, busy}, 1);
      rst_i = 1'b1;
      tick();
      chk_reset_vals("t6");
      rst_i = 1'b0;
      exp_q.delete();
      nr = n_rsp;
      lr = last_rise;
      repeat (50) tick();
      chk("t6_no_rsp", 64'(n_rsp), 64'(nr));
      chk("t6_no_rise", 64'(last_rise), 64'(lr));
      a_arr[1] = 5; b_arr[1] = 6; a_arr[3] = 7; b_arr[3] = 8; req_valid = 4'b1010;
      #1 chk("t6_ready", {60'b0, req_ready}, 4'b0010);
      wait_done("t6_done");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_tot);
      $fatal(1);
   end
endmodule
